// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: hold codes, NOP encoding and FSM states shared by the fetch unit and its bench.
package if_fetch_pkg;
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC = 3'd1;
  localparam logic [2:0] HOLD_IF = 3'd2;
  localparam logic [2:0] HOLD_ID = 3'd3;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: single-outstanding instruction bus, valid/ready request plus valid-only response.
interface if_fetch_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic req_ready;
  logic rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_err;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: PC owner issuing one instruction fetch at a time and delivering each as a one-cycle pulse.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [2:0]        hold_flag_i,
  if_fetch_if.master        bus,
  output logic              hold_flag_if_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              fetch_err_o
);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(INST_NOP);
  state_t state, state_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n, pc_n, inst_addr_n, jump_pend, jump_pend_n, jump_tgt, target;
  logic [DATA_W-1:0] inst_n;
  logic inst_valid_n, fetch_err_n, kill, kill_n;
  assign jump_tgt = jump_addr_i & ~ADDR_W'(3);
  assign target = jump_flag_i ? jump_tgt : jump_pend;
  assign bus.req_valid = state == REQ;
  assign bus.req_addr = req_addr;
  assign hold_flag_if_o = state != IDLE;
  always_comb begin
    state_n = state;
    req_addr_n = req_addr;
    pc_n = pc_o;
    inst_n = inst_o;
    inst_addr_n = inst_addr_o;
    inst_valid_n = 1'b0;
    fetch_err_n = 1'b0;
    kill_n = kill;
    jump_pend_n = jump_pend;
    case (state)
      IDLE: begin
        if (jump_flag_i) begin
          req_addr_n = jump_tgt;
          pc_n = jump_tgt;
          state_n = REQ;
        end else if (hold_flag_i < HOLD_PC) begin
          req_addr_n = pc_o;
          state_n = REQ;
        end
      end
      REQ: begin
        if (jump_flag_i) begin
          jump_pend_n = jump_tgt;
          kill_n = 1'b1;
        end
        if (bus.req_ready) state_n = RSP;
      end
      RSP: begin
        if (bus.rsp_valid && (kill || jump_flag_i)) begin
          // killed response: go straight back out with the redirect target
          req_addr_n = target;
          pc_n = target;
          kill_n = 1'b0;
          state_n = REQ;
        end else if (bus.rsp_valid) begin
          inst_n = bus.rsp_err ? NOP : bus.rsp_data;
          inst_addr_n = req_addr;
          inst_valid_n = 1'b1;
          fetch_err_n = bus.rsp_err;
          pc_n = req_addr + ADDR_W'(4);
          state_n = IDLE;
        end else if (jump_flag_i) begin
          jump_pend_n = jump_tgt;
          kill_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_addr <= '0;
      pc_o <= RESET_PC;
      inst_o <= NOP;
      inst_addr_o <= '0;
      inst_valid_o <= 1'b0;
      fetch_err_o <= 1'b0;
      kill <= 1'b0;
      jump_pend <= '0;
    end else begin
      state <= state_n;
      req_addr <= req_addr_n;
      pc_o <= pc_n;
      inst_o <= inst_n;
      inst_addr_o <= inst_addr_n;
      inst_valid_o <= inst_valid_n;
      fetch_err_o <= fetch_err_n;
      kill <= kill_n;
      jump_pend <= jump_pend_n;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vectors and corner sequences, then a random bus/jump/hold run against a transaction-level model.
module tb_if_fetch;
  import if_fetch_pkg::*;
  logic clk = 1'b0, rst = 1'b1, jump_flag = 1'b0, hold_if, inst_valid, fetch_err;
  logic [31:0] jump_addr = '0, pc, inst, inst_addr;
  logic [2:0] hold = HOLD_NONE;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] ja;
    int rdly;
    logic [31:0] data;
    logic err;
    logic [31:0] e_addr, e_inst, e_pc;
  } vec_t;
  vec_t vt[5];
  if_fetch_if bus();
  if_fetch dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .hold_flag_i(hold),
    .bus(bus), .hold_flag_if_o(hold_if), .pc_o(pc), .inst_o(inst), .inst_addr_o(inst_addr),
    .inst_valid_o(inst_valid), .fetch_err_o(fetch_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction
  function automatic logic errf(input logic [31:0] a);
    return a[4:2] == 3'd5;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic jump_to(input logic [31:0] a);
    jump_flag = 1'b1;
    jump_addr = a;
    tick();
    jump_flag = 1'b0;
  endtask
  task automatic serve(input int rdly, input logic [31:0] data, input logic err);
    logic [31:0] a;
    chk("serve_req_valid", bus.req_valid, 1);
    a = bus.req_addr;
    for (int k = 0; k < rdly; k++) begin
      tick();
      chk("stall_req_valid", bus.req_valid, 1);
      chk("stall_req_addr", bus.req_addr, a);
      chk("stall_hold_if", hold_if, 1);
    end
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    chk("rsp_wait_hold_if", hold_if, 1);
    chk("rsp_wait_req_valid", bus.req_valid, 0);
    bus.rsp_valid = 1'b1;
    bus.rsp_data = data;
    bus.rsp_err = err;
    tick();
    bus.rsp_valid = 1'b0;
    bus.rsp_err = 1'b0;
  endtask
  task automatic chk_dlv(input logic [31:0] ei, input logic [31:0] ea, input logic [31:0] epc, input logic eerr);
    chk("dlv_inst_valid", inst_valid, 1);
    chk("dlv_inst", inst, ei);
    chk("dlv_inst_addr", inst_addr, ea);
    chk("dlv_pc", pc, epc);
    chk("dlv_fetch_err", fetch_err, eerr);
    chk("dlv_hold_if", hold_if, 0);
  endtask
  task automatic chk_reset();
    chk("rst_pc", pc, 0);
    chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_hold_if", hold_if, 0);
    chk("rst_inst", inst, INST_NOP);
    chk("rst_inst_addr", inst_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_fetch_err", fetch_err, 0);
  endtask
  initial begin
    logic outst, taint, dlv, dlv_err, chk_req, exp_req, stall, rsp, busy;
    logic [31:0] out_addr, exp_next, dlv_addr, stall_addr;
    vt[0] = '{32'h0000_0000, 0, 32'h0050_0093, 1'b0, 32'h0000_0000, 32'h0050_0093, 32'h0000_0004};
    vt[1] = '{32'h0000_0008, 2, 32'hDEAD_BEEF, 1'b1, 32'h0000_0008, 32'h0000_0013, 32'h0000_000C};
    vt[2] = '{32'hFFFF_FFFC, 1, 32'h1234_5678, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0000};
    vt[3] = '{32'h0000_0103, 4, 32'h00A0_0113, 1'b0, 32'h0000_0100, 32'h00A0_0113, 32'h0000_0104};
    vt[4] = '{32'h7FFF_FFFE, 3, 32'hCAFE_F00D, 1'b1, 32'h7FFF_FFFC, 32'h0000_0013, 32'h8000_0000};
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = '0;
    bus.rsp_err = 1'b0;
    repeat (3) tick();
    chk_reset();
    rst = 1'b0;
    tick();
    chk("t1_req_valid", bus.req_valid, 1);
    chk("t1_req_addr", bus.req_addr, 0);
    chk("t1_hold_if", hold_if, 1);
    serve(0, 32'h0050_0093, 1'b0);
    chk_dlv(32'h0050_0093, 32'h0, 32'h4, 1'b0);
    hold = HOLD_ID;
    tick();
    chk("t1_pulse_end", inst_valid, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_no_req", bus.req_valid, 0);
      chk("t4_hold_if_low", hold_if, 0);
    end
    jump_to(32'h0000_0040);
    chk("t4_jump_req_valid", bus.req_valid, 1);
    chk("t4_jump_req_addr", bus.req_addr, 32'h40);
    serve(0, 32'h1111_2222, 1'b0);
    chk_dlv(32'h1111_2222, 32'h40, 32'h44, 1'b0);
    foreach (vt[i]) begin
      jump_to(vt[i].ja);
      chk("vec_req_addr", bus.req_addr, vt[i].e_addr);
      chk("vec_pc_redirect", pc, vt[i].e_addr);
      serve(vt[i].rdly, vt[i].data, vt[i].err);
      chk_dlv(vt[i].e_inst, vt[i].e_addr, vt[i].e_pc, vt[i].err);
    end
    jump_to(32'h0000_0200);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    jump_to(32'h0000_0103);
    chk("t3_kill_hold_if", hold_if, 1);
    bus.rsp_valid = 1'b1;
    bus.rsp_data = 32'hBAD0_BAD0;
    tick();
    bus.rsp_valid = 1'b0;
    chk("t3_discard", inst_valid, 0);
    chk("t3_req_addr", bus.req_addr, 32'h100);
    chk("t3_pc", pc, 32'h100);
    serve(0, 32'h00A0_0113, 1'b0);
    chk_dlv(32'h00A0_0113, 32'h100, 32'h104, 1'b0);
    jump_to(32'h0000_0300);
    jump_to(32'h0000_0500);
    chk("req_jump_addr_stable", bus.req_addr, 32'h300);
    serve(0, 32'hBAD1_BAD1, 1'b0);
    chk("req_jump_discard", inst_valid, 0);
    chk("req_jump_readdr", bus.req_addr, 32'h500);
    serve(1, 32'h0000_0533, 1'b0);
    chk_dlv(32'h0000_0533, 32'h500, 32'h504, 1'b0);
    jump_to(32'h0000_0600);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_data = 32'hBAD2_BAD2;
    jump_to(32'h0000_0700);
    bus.rsp_valid = 1'b0;
    chk("rsp_jump_discard", inst_valid, 0);
    chk("rsp_jump_readdr", bus.req_addr, 32'h700);
    serve(0, 32'h0000_0733, 1'b0);
    chk_dlv(32'h0000_0733, 32'h700, 32'h704, 1'b0);
    jump_to(32'h0000_0080);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset();
    bus.rsp_valid = 1'b1;
    tick();
    bus.rsp_valid = 1'b0;
    chk("stray_rsp_ignored", inst_valid, 0);
    chk("stray_rsp_no_req", bus.req_valid, 0);
    outst = 0; taint = 0; dlv = 0; dlv_err = 0; chk_req = 0; exp_req = 0; stall = 0;
    out_addr = '0; exp_next = '0; dlv_addr = '0; stall_addr = '0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      chk("rnd_inst_valid", inst_valid, dlv);
      if (dlv) begin
        chk("rnd_inst_addr", inst_addr, dlv_addr);
        chk("rnd_inst", inst, dlv_err ? INST_NOP : mem(dlv_addr));
        chk("rnd_fetch_err", fetch_err, dlv_err);
        chk("rnd_pc", pc, dlv_addr + 32'd4);
      end else chk("rnd_no_err", fetch_err, 0);
      chk("rnd_hold_if", hold_if, bus.req_valid || outst);
      if (chk_req) chk("rnd_issue", bus.req_valid, exp_req);
      if (stall) begin
        chk("rnd_stall_valid", bus.req_valid, 1);
        chk("rnd_stall_addr", bus.req_addr, stall_addr);
      end
      busy = bus.req_valid || outst;
      jump_flag = (i == 0) || ($urandom_range(0, 11) == 0);
      jump_addr = (i == 0) ? 32'h0000_1000 : $urandom;
      hold = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : HOLD_NONE;
      rsp = outst && ($urandom_range(0, 2) != 0);
      bus.rsp_valid = rsp;
      bus.rsp_data = rsp ? mem(out_addr) : $urandom;
      bus.rsp_err = rsp && errf(out_addr);
      dlv = rsp && !taint && !jump_flag;
      if (dlv) begin
        chk("rnd_fetch_addr", out_addr, exp_next);
        dlv_addr = out_addr;
        dlv_err = errf(out_addr);
        exp_next = out_addr + 32'd4;
      end
      if (rsp) begin
        taint = 0;
        outst = 0;
      end else if (jump_flag && busy) taint = 1;
      if (jump_flag) exp_next = jump_addr & ~32'h3;
      chk_req = !busy;
      exp_req = jump_flag || hold == HOLD_NONE;
      bus.req_ready = 1'($urandom_range(0, 1));
      stall = bus.req_valid && !bus.req_ready;
      stall_addr = bus.req_addr;
      if (bus.req_valid && bus.req_ready) begin
        outst = 1;
        out_addr = bus.req_addr;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
